ads_bus_slave_port: RTL and testbench

- Responder end of the ADS serial bus: the slave-side bit-serial interface behind the address decoder.
- Receives a serial address, then either receives serial write data into a local register file or shifts out serial read data.
- Supports the bus split mechanism: a busy slave parks the transaction, releases the bus, and later requests the arbiter to resume it.
- One instance per slave (slave1/2/3) inside ADS_BUS.

---
 rtl/ads_bus_slave_port.sv | 194 +++++++++++++++++++
 tb/tb_ads_bus_slave_port.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ads_bus_slave_port.sv
// Slave-side bit-serial port of the ADS bus: serial address, then serial write
// into a local register file or serial read-out, with split/resume support.
`timescale 1ns/1ps

module ads_bus_slave_port #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int SPLIT_EN = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sel,
  input  logic              rw,
  input  logic              s_in,
  input  logic              s_valid,
  input  logic              busy,
  input  logic              split_gnt,
  output logic              s_out,
  output logic              s_out_valid,
  output logic              ready,
  output logic              split,
  output logic              split_req,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        state
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ADDR   = 4'd1,
    WDATA  = 4'd2,
    RDATA  = 4'd3,
    SPLIT  = 4'd4,
    RESUME = 4'd5,
    DONE   = 4'd6
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rd_word;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      data_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
    end
  end

  // NOTE: the register file is cleared by reset, so it cannot map onto a RAM
  // macro; that is intended, reset must discard all stored words.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= data_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel) begin
          rw_d    = rw;
          state_d = ADDR;
          addr_d  = '0;
          data_d  = '0;
          cnt_d   = '0;
          if (s_valid) begin
            addr_d[0] = s_in;
            cnt_d     = CNT_W'(1);
          end
        end
      end
      ADDR: begin
        if (!sel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s_valid) begin
          for (int i = 0; i < ADDR_W; i++)
            if (cnt_q == CNT_W'(i)) addr_d[i] = s_in;
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            if (busy && (SPLIT_EN != 0)) state_d = SPLIT;
            else                         state_d = rw_q ? WDATA : RDATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WDATA: begin
        if (!sel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s_valid) begin
          for (int i = 0; i < DATA_W; i++)
            if (cnt_q == CNT_W'(i)) data_d[i] = s_in;
          if (cnt_q == DATA_LAST) begin
            wdata_d = data_d;
            mem_we  = 1'b1;
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RDATA: begin
        if (!sel || cnt_q == DATA_LAST) begin
          state_d = sel ? DONE : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SPLIT: begin
        if (!busy) state_d = RESUME;
      end
      RESUME: begin
        // Only the data phase is resent; the parked address is reused.
        if (split_gnt && sel) begin
          state_d = rw_q ? WDATA : RDATA;
          cnt_d   = '0;
          data_d  = '0;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rd_word = mem_q[addr_q];

  always_comb begin
    s_out       = 1'b0;
    s_out_valid = 1'b0;
    ready       = 1'b0;
    split       = 1'b0;
    split_req   = 1'b0;
    unique case (state_q)
      RDATA: begin
        // Gated by sel so an abort drops the read stream in the same cycle.
        s_out_valid = sel;
        for (int i = 0; i < DATA_W; i++)
          if (cnt_q == CNT_W'(i)) s_out = sel & rd_word[i];
      end
      DONE:   ready = 1'b1;
      SPLIT:  split = 1'b1;
      RESUME: begin
        split     = 1'b1;
        split_req = 1'b1;
      end
      default: ;
    endcase
  end

  assign wdata = wdata_q;
  assign state = state_q;

endmodule

// File: tb/tb_ads_bus_slave_port.sv
// Directed self-checking bench for ads_bus_slave_port: write, read-back,
// stalls, split/resume, abort and reset in the middle of a split.
`timescale 1ns/1ps

module tb_ads_bus_slave_port;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sel, rw, s_in, s_valid, busy, split_gnt;
  logic       s_out, s_out_valid, ready, split, split_req;
  logic [7:0] wdata;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  ads_bus_slave_port #(.ADDR_W(4), .DATA_W(8), .SPLIT_EN(1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sel        (sel),
    .rw         (rw),
    .s_in       (s_in),
    .s_valid    (s_valid),
    .busy       (busy),
    .split_gnt  (split_gnt),
    .s_out      (s_out),
    .s_out_valid(s_out_valid),
    .ready      (ready),
    .split      (split),
    .split_req  (split_req),
    .wdata      (wdata),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic shift(input logic [7:0] v, input int lo, input int hi, input bit stall);
    for (int i = lo; i <= hi; i++) begin
      if (stall && i > lo) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_in    = v[i];
      tick();
    end
  endtask

  task automatic read_check(input logic [3:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] got;
    int         nvalid;
    sel  = 1'b1;
    rw   = 1'b0;
    busy = 1'b0;
    shift({4'h0, a}, 0, 3, 1'b0);
    s_valid = 1'b0;
    got     = '0;
    nvalid  = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_out_valid === 1'b1) nvalid++;
      got[i] = s_out;
      tick();
    end
    check({tag, "_data"}, got, exp);
    check({tag, "_nvalid"}, nvalid, 8);
    check({tag, "_ready"}, ready, 1);
    sel = 1'b0;
    tick();
  endtask

  initial begin
    int bad;
    rstn = 1'b0; sel = 1'b0; rw = 1'b0; s_in = 1'b0; s_valid = 1'b0;
    busy = 1'b0; split_gnt = 1'b0;
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_outs", {s_out, s_out_valid, ready, split, split_req}, 5'b0);
    check("rst_wdata", wdata, 8'h00);
    rstn = 1'b1;
    tick();

    // Write 0x A5 to address 5, continuous s_valid.
    sel = 1'b1; rw = 1'b1; s_valid = 1'b1; s_in = 1'b1;
    tick();
    check("wr_state_addr", state, 1);
    shift(8'h05, 1, 3, 1'b0);
    check("wr_state_wdata", state, 2);
    shift(8'hA5, 0, 6, 1'b0);
    check("wr_ready_early", ready, 0);
    shift(8'hA5, 7, 7, 1'b0);
    check("wr_state_done", state, 6);
    check("wr_ready", ready, 1);
    check("wr_wdata", wdata, 8'hA5);
    sel = 1'b0; s_valid = 1'b0;
    tick();
    check("wr_state_idle", state, 0);
    check("wr_ready_one_cycle", ready, 0);

    read_check(4'h5, 8'hA5, "rd5");

    // Stalled write of 0x3C to address 3.
    sel = 1'b1; rw = 1'b1;
    shift(8'h03, 0, 3, 1'b1);
    shift(8'h3C, 0, 6, 1'b1);
    s_valid = 1'b0;
    tick();
    check("stall_ready_early", ready, 0);
    shift(8'h3C, 7, 7, 1'b0);
    check("stall_ready", ready, 1);
    check("stall_wdata", wdata, 8'h3C);
    sel = 1'b0; s_valid = 1'b0;
    tick();
    read_check(4'h3, 8'h3C, "rd3");

    // Split: busy at the end of the address phase of a write to address 2.
    sel = 1'b1; rw = 1'b1; busy = 1'b1;
    shift(8'h02, 0, 3, 1'b0);
    s_valid = 1'b0; sel = 1'b0;
    check("split_state", state, 4);
    check("split_flag", split, 1);
    check("split_no_req", split_req, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (split !== 1'b1 || split_req !== 1'b0 || state !== 4'd4) bad++;
    end
    check("split_hold", bad, 0);
    busy = 1'b0;
    tick();
    check("resume_state", state, 5);
    check("resume_req", {split, split_req}, 2'b11);
    tick(); tick();
    check("resume_wait_gnt", state, 5);
    sel = 1'b1; split_gnt = 1'b1;
    tick();
    split_gnt = 1'b0;
    check("resume_to_wdata", state, 2);
    check("resume_cleared", {split, split_req}, 2'b00);
    shift(8'h81, 0, 7, 1'b0);
    check("split_ready", ready, 1);
    check("split_wdata", wdata, 8'h81);
    sel = 1'b0; s_valid = 1'b0;
    tick();
    read_check(4'h2, 8'h81, "rd2");

    // Abort a write to address 5 after three data bits.
    sel = 1'b1; rw = 1'b1;
    shift(8'h05, 0, 3, 1'b0);
    shift(8'hFF, 0, 2, 1'b0);
    check("abort_in_wdata", state, 2);
    sel = 1'b0; s_valid = 1'b0;
    tick();
    check("abort_state", state, 0);
    check("abort_no_ready", ready, 0);
    check("abort_wdata", wdata, 8'h81);
    read_check(4'h5, 8'hA5, "rd5_after_abort");

    // Abort a read: s_out_valid must drop in the same cycle sel falls.
    sel = 1'b1; rw = 1'b0;
    shift(8'h03, 0, 3, 1'b0);
    s_valid = 1'b0;
    check("rabort_valid_on", s_out_valid, 1);
    tick(); tick();
    sel = 1'b0;
    #1;
    check("rabort_valid_drop", s_out_valid, 0);
    tick();
    check("rabort_state", state, 0);
    check("rabort_no_ready", ready, 0);

    // Asynchronous reset while parked in RESUME.
    sel = 1'b1; rw = 1'b1; busy = 1'b1;
    shift(8'h07, 0, 3, 1'b0);
    s_valid = 1'b0; sel = 1'b0; busy = 1'b0;
    check("rsplit_state", state, 4);
    tick();
    check("rsplit_resume", state, 5);
    #2 rstn = 1'b0;
    #1;
    check("rsplit_state_rst", state, 0);
    check("rsplit_flags_rst", {split, split_req}, 2'b00);
    check("rsplit_wdata_rst", wdata, 8'h00);
    rstn = 1'b1;
    tick();
    read_check(4'h5, 8'h00, "rd5_after_rst");
    read_check(4'h2, 8'h00, "rd2_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
